// File: rtl/rv_pkg.sv
// Shared register-file writeback types and constants.
// Holds the request bundle queued between the execution units and the write port.
package rv_pkg;

   localparam int XLEN       = 32;
   localparam int REG_ADDR_W = 5;
   localparam int NUM_REGS   = 2 ** REG_ADDR_W;

   typedef struct packed {
      logic [REG_ADDR_W-1:0] rd;
      logic [XLEN-1:0]       data;
   } wb_req_t;

   function automatic logic [NUM_REGS-1:0] onehot(
      input logic [REG_ADDR_W-1:0] idx
   );
      logic [NUM_REGS-1:0] v;
      v      = '0;
      v[idx] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Count-based synchronous FIFO that also exposes every slot and its
// occupancy bit, so the owner can search the queued contents.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         i_push,
   input  logic [WIDTH-1:0]             i_data,
   input  logic                         i_pop,
   output logic [WIDTH-1:0]             o_head,
   output logic                         o_full,
   output logic                         o_empty,
   output logic [$clog2(DEPTH):0]       o_count,
   output logic [DEPTH-1:0][WIDTH-1:0]  o_entries,
   output logic [DEPTH-1:0]             o_valid
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [DEPTH-1:0][WIDTH-1:0] r_mem;
   logic [AW-1:0]               r_wr_ptr;
   logic [AW-1:0]               r_rd_ptr;
   logic [CW-1:0]               r_count;
   logic                        w_push;
   logic                        w_pop;

   assign o_full    = (r_count == CW'(DEPTH));
   assign o_empty   = (r_count == '0);
   assign o_count   = r_count;
   assign o_head    = r_mem[r_rd_ptr];
   assign o_entries = r_mem;

   assign w_push = i_push && !o_full;
   assign w_pop  = i_pop && !o_empty;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
            r_wr_ptr        <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
   end

   // A slot is live when its distance from the read pointer is below the count.
   always_comb begin
      logic [AW-1:0] w_off;
      o_valid = '0;
      for (int i = 0; i < DEPTH; i++) begin
         w_off      = AW'(i) - r_rd_ptr;
         o_valid[i] = (CW'(w_off) < r_count);
      end
   end

endmodule

// File: rtl/rf_writeback_arbiter.sv
// Merges ALU (priority) and buffered load/mul results onto the single
// register-file write port, keeping write-after-write order per register.
module rf_writeback_arbiter
   import rv_pkg::*;
#(
   parameter int FIFO_DEPTH = 4
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        a_valid,
   output logic                        a_ready,
   input  logic [REG_ADDR_W-1:0]       a_rd,
   input  logic [XLEN-1:0]             a_data,
   input  logic                        b_valid,
   output logic                        b_ready,
   input  logic [REG_ADDR_W-1:0]       b_rd,
   input  logic [XLEN-1:0]             b_data,
   output logic                        rf_wr_en,
   output logic [REG_ADDR_W-1:0]       rf_rd_addr,
   output logic [XLEN-1:0]             rf_rd_data,
   output logic [NUM_REGS-1:0]         pending_mask,
   output logic [$clog2(FIFO_DEPTH):0] b_count
);

   localparam int WB_W = $bits(wb_req_t);

   logic                            w_full;
   logic                            w_empty;
   logic                            w_push;
   logic                            w_pop;
   logic                            w_a_xfer;
   wb_req_t                         w_b_req;
   wb_req_t                         w_head;
   logic [FIFO_DEPTH-1:0][WB_W-1:0] w_entries;
   logic [FIFO_DEPTH-1:0]           w_valid;
   logic [NUM_REGS-1:0]             w_fifo_mask;

   logic                            r_wr_en;
   logic [REG_ADDR_W-1:0]           r_addr;
   logic [XLEN-1:0]                 r_data;

   assign w_b_req = {b_rd, b_data};

   sync_fifo #(
      .WIDTH (WB_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .i_push    (w_push),
      .i_data    (w_b_req),
      .i_pop     (w_pop),
      .o_head    (w_head),
      .o_full    (w_full),
      .o_empty   (w_empty),
      .o_count   (b_count),
      .o_entries (w_entries),
      .o_valid   (w_valid)
   );

   always_comb begin
      wb_req_t w_e;
      w_fifo_mask = '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
         w_e = w_entries[i];
         if (w_valid[i]) begin
            w_fifo_mask[w_e.rd] = 1'b1;
         end
      end
   end

   // A must not overtake an older queued B write to the same register.
   assign a_ready  = !((a_rd != '0) && w_fifo_mask[a_rd]);
   assign b_ready  = !w_full;
   assign w_a_xfer = a_valid && a_ready;
   assign w_push   = b_valid && !w_full;
   assign w_pop    = !w_a_xfer && !w_empty;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_en <= 1'b0;
         r_addr  <= '0;
         r_data  <= '0;
      end else if (w_a_xfer) begin
         r_wr_en <= (a_rd != '0);
         r_addr  <= a_rd;
         r_data  <= a_data;
      end else if (!w_empty) begin
         r_wr_en <= (w_head.rd != '0);
         r_addr  <= w_head.rd;
         r_data  <= w_head.data;
      end else begin
         r_wr_en <= 1'b0;
      end
   end

   assign rf_wr_en   = r_wr_en;
   assign rf_rd_addr = r_addr;
   assign rf_rd_data = r_data;

   always_comb begin
      pending_mask = w_fifo_mask;
      if (r_wr_en) begin
         pending_mask = pending_mask | onehot(r_addr);
      end
      pending_mask[0] = 1'b0;
   end

endmodule

// File: tb/tb_rf_writeback_arbiter.sv
// Bench for rf_writeback_arbiter: queue-based reference model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_rf_writeback_arbiter;

   logic        clk;
   logic        rst;
   logic        a_valid;
   logic        a_ready;
   logic [4:0]  a_rd;
   logic [31:0] a_data;
   logic        b_valid;
   logic        b_ready;
   logic [4:0]  b_rd;
   logic [31:0] b_data;
   logic        rf_wr_en;
   logic [4:0]  rf_rd_addr;
   logic [31:0] rf_rd_data;
   logic [31:0] pending_mask;
   logic [2:0]  b_count;

   int n_chk = 0;
   int n_pass = 0;
   int n_wr = 0;

   rf_writeback_arbiter dut (
      .clk          (clk),
      .rst          (rst),
      .a_valid      (a_valid),
      .a_ready      (a_ready),
      .a_rd         (a_rd),
      .a_data       (a_data),
      .b_valid      (b_valid),
      .b_ready      (b_ready),
      .b_rd         (b_rd),
      .b_data       (b_data),
      .rf_wr_en     (rf_wr_en),
      .rf_rd_addr   (rf_rd_addr),
      .rf_rd_data   (rf_rd_data),
      .pending_mask (pending_mask),
      .b_count      (b_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h want %0h", nm, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference model: plain queue of pending B results plus the write stage.
   typedef struct {
      logic [4:0]  rd;
      logic [31:0] d;
   } ent_t;

   ent_t        q[$];
   logic        m_wr = 1'b0;
   logic [4:0]  m_addr = '0;
   logic [31:0] m_data = '0;
   bit          mv = 0;
   bit          a_fire = 0;
   bit          b_fire = 0;

   always @(negedge clk) begin : model
      logic [31:0] fm;
      logic [31:0] e_pm;
      logic        e_ar;
      logic        e_br;
      ent_t        h;
      fm = '0;
      foreach (q[i]) fm[q[i].rd] = 1'b1;
      e_ar = (a_rd == 5'd0) || !fm[a_rd];
      e_br = (q.size() < 4);
      e_pm = fm | (m_wr ? (32'd1 << m_addr) : 32'd0);
      e_pm[0] = 1'b0;
      if (mv) begin
         chk("m_a_ready", a_ready, e_ar);
         chk("m_b_ready", b_ready, e_br);
         chk("m_b_count", b_count, q.size());
         chk("m_pending", pending_mask, e_pm);
         chk("m_wr_en", rf_wr_en, m_wr);
         if (m_wr) begin
            chk("m_addr", rf_rd_addr, m_addr);
            chk("m_data", rf_rd_data, m_data);
         end
      end
      if (rf_wr_en === 1'b1) n_wr++;
      a_fire = 0;
      b_fire = 0;
      if (rst) begin
         q.delete();
         m_wr = 1'b0;
         m_addr = '0;
         m_data = '0;
         mv = 1;
      end else if (mv) begin
         a_fire = a_valid && e_ar;
         b_fire = b_valid && e_br;
         if (a_fire) begin
            m_wr = (a_rd != 5'd0);
            m_addr = a_rd;
            m_data = a_data;
         end else if (q.size() > 0) begin
            h = q.pop_front();
            m_wr = (h.rd != 5'd0);
            m_addr = h.rd;
            m_data = h.d;
         end else begin
            m_wr = 1'b0;
         end
         if (b_fire) q.push_back('{b_rd, b_data});
      end
   end

   initial begin
      logic [4:0] t6rd [3];
      int mark;
      t6rd = '{5'd6, 5'd7, 5'd0};
      rst = 1; a_valid = 0; a_rd = 0; a_data = 0;
      b_valid = 0; b_rd = 0; b_data = 0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_wr_en", rf_wr_en, 0);
      chk("rst_addr", rf_rd_addr, 0);
      chk("rst_data", rf_rd_data, 0);
      chk("rst_count", b_count, 0);
      chk("rst_pending", pending_mask, 0);
      chk("rst_a_ready", a_ready, 1);
      chk("rst_b_ready", b_ready, 1);
      rst = 0;

      // A only
      a_valid = 1; a_rd = 3; a_data = 32'hDEADBEEF;
      tick(); a_valid = 0; #1;
      chk("t1_wr_en", rf_wr_en, 1);
      chk("t1_addr", rf_rd_addr, 3);
      chk("t1_data", rf_rd_data, 32'hDEADBEEF);
      chk("t1_pending", pending_mask, 32'h8);

      // A and B together
      a_valid = 1; a_rd = 1; a_data = 32'h11;
      b_valid = 1; b_rd = 2; b_data = 32'h22;
      tick(); a_valid = 0; b_valid = 0; #1;
      chk("t2_addr1", rf_rd_addr, 1);
      chk("t2_data1", rf_rd_data, 32'h11);
      chk("t2_count1", b_count, 1);
      chk("t2_pend1", pending_mask, 32'h6);
      tick();
      chk("t2_wr_en2", rf_wr_en, 1);
      chk("t2_addr2", rf_rd_addr, 2);
      chk("t2_data2", rf_rd_data, 32'h22);
      chk("t2_count2", b_count, 0);
      tick();
      chk("t2_idle", rf_wr_en, 0);

      // WAW on x5
      b_valid = 1; b_rd = 5; b_data = 32'hAA;
      tick(); b_valid = 0;
      a_valid = 1; a_rd = 5; a_data = 32'hBB; #1;
      chk("t3_stall", a_ready, 0);
      chk("t3_pend", pending_mask, 32'h20);
      tick();
      chk("t3_addr_aa", rf_rd_addr, 5);
      chk("t3_data_aa", rf_rd_data, 32'hAA);
      chk("t3_ready", a_ready, 1);
      tick(); a_valid = 0; #1;
      chk("t3_wr_bb", rf_wr_en, 1);
      chk("t3_data_bb", rf_rd_data, 32'hBB);

      // Fill FIFO while A keeps the port busy
      a_valid = 1; a_rd = 20; a_data = 32'h77;
      for (int i = 0; i < 4; i++) begin
         b_valid = 1; b_rd = 5'(8 + i); b_data = 32'(32'h100 + i);
         tick();
      end
      b_rd = 12; b_data = 32'h104; #1;
      chk("t4_full_cnt", b_count, 4);
      chk("t4_b_ready", b_ready, 0);
      tick(); a_valid = 0; b_valid = 0; #1;
      chk("t4_no_push", b_count, 4);
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("t4_drain_cnt", b_count, 3 - i);
         chk("t4_drain_we", rf_wr_en, 1);
         chk("t4_drain_addr", rf_rd_addr, 8 + i);
         chk("t4_drain_data", rf_rd_data, 32'h100 + i);
      end

      // x0 from A
      a_valid = 1; a_rd = 0; a_data = 32'h55; #1;
      chk("t5_a_ready", a_ready, 1);
      tick(); a_valid = 0; #1;
      chk("t5_wr_en", rf_wr_en, 0);
      chk("t5_pending", pending_mask, 0);

      // Reset with entries queued
      a_valid = 1; a_rd = 20; a_data = 32'h66;
      for (int i = 0; i < 3; i++) begin
         b_valid = 1; b_rd = t6rd[i]; b_data = 32'(32'h200 + i);
         tick();
      end
      b_valid = 0; a_rd = 0; #1;
      chk("t6_x0_ready", a_ready, 1);
      chk("t6_count", b_count, 3);
      chk("t6_pending", pending_mask, 32'h001000C0);
      a_valid = 0; rst = 1;
      tick(); rst = 0; #1;
      chk("t6_wr_en", rf_wr_en, 0);
      chk("t6_count0", b_count, 0);
      chk("t6_pend0", pending_mask, 0);
      mark = n_wr;
      repeat (6) tick();
      chk("t6_no_write", n_wr - mark, 0);

      // Randomized traffic, handshake-compliant
      repeat (3000) begin
         tick();
         rst = ($urandom_range(0, 199) == 0);
         if (!a_valid || a_fire) begin
            a_valid = ($urandom_range(0, 1) == 1);
            a_rd = 5'($urandom_range(0, 7));
            a_data = $urandom;
         end
         if (!b_valid || b_fire) begin
            b_valid = ($urandom_range(0, 9) < 6);
            b_rd = 5'($urandom_range(0, 7));
            b_data = $urandom;
         end
      end
      tick();
      a_valid = 0; b_valid = 0; rst = 0;
      repeat (8) tick();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
